cache_victim_wb: RTL

Victim writeback buffer on the cache's eviction path. When the replacement policy selects a dirty victim way, the cache hands the whole line to this block in one cycle. The block queues the line and drains it to the bus as a fixed-length write burst, so the cache can refill without waiting for the writeback. It also reports whether an address hits a queued line, so the cache can stall a refill that would read memory before that line's writeback completes.

---
 rtl/cache_wb_pkg.sv | 20 ++
 rtl/victim_fifo.sv | 75 +++++++
 rtl/cache_victim_wb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_wb_pkg.sv
// Shared types and sizing helpers for the victim writeback buffer.
// Pure declarations: no latency, no flow control.
package cache_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } drain_state_t;

    function automatic int beats_of(input int linelen, input int wordlen);
        return linelen / wordlen;
    endfunction

    // A one-beat line still needs a 1-bit beat index port.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/victim_fifo.sv
// Circular store of whole victim lines with per-entry valid flags for address lookup.
// Latency: push visible at head/valid one cycle later; pop frees its slot one cycle later; caller never pushes when full.
module victim_fifo #(
    parameter int DEPTH   = 2,
    parameter int LINELEN = 512,
    parameter int PA_BITS = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            push,
    input  logic [PA_BITS-1:0]              push_adr,
    input  logic [LINELEN-1:0]              push_line,
    input  logic                            pop,
    output logic [PA_BITS-1:0]              head_adr,
    output logic [LINELEN-1:0]              head_line,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                entry_vld,
    output logic [DEPTH-1:0][PA_BITS-1:0]   entry_adr,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LINELEN-1:0]              line_q [DEPTH];
    logic [DEPTH-1:0][PA_BITS-1:0]   adr_q;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                cnt_q;
    logic [PTR_W-1:0]                ofs [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Line payload is not reset: only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            line_q[wr_ptr] <= push_line;
            adr_q[wr_ptr]  <= push_adr;
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ofs[i]       = PTR_W'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, ofs[i]} < cnt_q);
        end
    end

    assign head_adr  = adr_q[rd_ptr];
    assign head_line = line_q[rd_ptr];
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign entry_adr = adr_q;
    assign count     = cnt_q;

endmodule

// File: rtl/cache_victim_wb.sv
// Victim writeback buffer: queues dirty lines and drains each as a fixed-length write burst.
// Latency: enqueue at edge N gives BusReq from N+1; full holds off EvictValid; BusReady stalls beats in place.
module cache_victim_wb
    import cache_wb_pkg::*;
#(
    parameter int LINELEN = 512,
    parameter int WORDLEN = 64,
    parameter int PA_BITS = 32,
    parameter int DEPTH   = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic                                                   EvictValid,
    output logic                                                   EvictReady,
    input  logic [PA_BITS-1:0]                                     EvictAdr,
    input  logic [LINELEN-1:0]                                     EvictLine,
    input  logic [PA_BITS-1:0]                                     LookupAdr,
    output logic                                                   LookupHit,
    output logic                                                   BusReq,
    output logic [PA_BITS-1:0]                                     BusAdr,
    output logic [WORDLEN-1:0]                                     BusWData,
    output logic [beat_bits(beats_of(LINELEN, WORDLEN))-1:0]       BusBeat,
    output logic                                                   BusLast,
    input  logic                                                   BusReady,
    input  logic                                                   BusAck,
    output logic                                                   Empty
);

    localparam int BEATS    = beats_of(LINELEN, WORDLEN);
    localparam int BEAT_W   = beat_bits(BEATS);
    localparam int OFF_BITS = $clog2(LINELEN / 8);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [PA_BITS-1:0] LINE_MASK  = ~((PA_BITS'(1) << OFF_BITS) - PA_BITS'(1));
    localparam logic [PA_BITS-1:0] BEAT_BYTES = PA_BITS'(WORDLEN / 8);

    drain_state_t                  state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          push, pop, last_beat;
    logic                          fifo_full, fifo_empty;
    logic [PA_BITS-1:0]            head_adr;
    logic [LINELEN-1:0]            head_line;
    logic [DEPTH-1:0]              entry_vld;
    logic [DEPTH-1:0][PA_BITS-1:0] entry_adr;
    logic [CNT_W-1:0]              fifo_count;

    assign push = EvictValid && EvictReady;

    victim_fifo #(
        .DEPTH   (DEPTH),
        .LINELEN (LINELEN),
        .PA_BITS (PA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_adr  (EvictAdr & LINE_MASK),
        .push_line (EvictLine),
        .pop       (pop),
        .head_adr  (head_adr),
        .head_line (head_line),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entry_vld (entry_vld),
        .entry_adr (entry_adr),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // The beat counter parks on the last beat through RESP and clears with the pop.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || push)
                    state_d = BURST;
            end
            BURST: begin
                if (BusReady) begin
                    if (last_beat)
                        state_d = RESP;
                    else
                        beat_d = beat_q + 1'b1;
                end
            end
            RESP: begin
                if (BusAck) begin
                    pop     = 1'b1;
                    beat_d  = '0;
                    state_d = ((fifo_count > CNT_W'(1)) || push) ? BURST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BusReq     = (state_q == BURST);
    assign BusLast    = BusReq && last_beat;
    assign BusBeat    = beat_q;
    assign BusAdr     = head_adr + PA_BITS'(beat_q) * BEAT_BYTES;
    assign BusWData   = head_line[int'(beat_q) * WORDLEN +: WORDLEN];
    assign EvictReady = !fifo_full;
    assign Empty      = fifo_empty;

    // The head keeps its valid flag until popped, so refills stall through RESP too.
    always_comb begin
        LookupHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_adr[i] == (LookupAdr & LINE_MASK)))
                LookupHit = 1'b1;
        end
    end

endmodule
